irq_prio_ctrl: RTL
==================

Name: irq_prio_ctrl

Overview:
- Interrupt controller for the CPU core.
- Latches rising edges on M = 2^WIDTH interrupt sources and masks them.
- Uses a prio_enc instance to pick the highest-numbered enabled pending source.
- Sequences an irq/ack/eoi handshake with the core: one interrupt in service at a time, no nesting.

Parameters:
WIDTH, 4, log2 of source count; M = 1<<WIDTH sources (default 16); vector width = WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
src  input  M  interrupt source levels, synchronous to clk; rising edge = request
mask_we  input  1  write strobe for mask register
mask_din  input  M  new mask value (1 = source enabled)
mask  output  M  current mask register
pending  output  M  current pending-latch register
irq  output  1  interrupt request to core
vector  output  WIDTH  number of the source being requested / serviced
ack  input  1  core accepts current request (single-cycle pulse)
eoi  input  1  core signals end of interrupt service (single-cycle pulse)
busy  output  1  an interrupt is in service

Behaviour:
- Reset (reset=1 at clk edge):
  - Registers: pending=0, mask=0, irq=0, vector=0, busy=0, state=IDLE.
  - src_q <= src, so sources already high at reset release do not produce an edge.
  - Reset overrides every other input, including mid-handshake.
- Edge detect:
  - edge = src & ~src_q; src_q <= src every cycle.
  - pending[i] set when edge[i].
- Pending clear and priority:
  - pending[vector] is cleared on an accepted ack.
  - If set and clear hit the same bit in the same cycle, set wins (the new edge is kept).
- Mask:
  - On mask_we, mask <= mask_din at the next edge.
  - Masking never clears pending. A masked pending bit fires once unmasked.
- Selection:
  - req = pending & mask.
  - sel = prio_enc(req): highest set bit index, 0 if req == 0.
  - Purely combinational on registered pending/mask.
- State machine, states IDLE, REQ, SERVICE:
  - IDLE:
    - If req != 0: vector <= sel, irq <= 1, go REQ.
    - Latency: src rising at edge k -> pending at k+1 -> irq high after edge k+2.
  - REQ:
    - irq held high. vector <= sel each cycle, so a higher-numbered arrival pre-empts the vector before ack.
    - If ack: clear pending[vector] (the currently presented vector), irq <= 0, busy <= 1, go SERVICE; vector holds.
    - Else if req == 0 (all masked off): irq <= 0, go IDLE; vector holds last value.
    - ack takes priority over the req==0 check in the same cycle only if req != 0. If req == 0 and ack, treat as withdrawal: no pending cleared, go IDLE.
  - SERVICE:
    - irq=0, busy=1, vector stable.
    - New edges still latch into pending.
    - On eoi: busy <= 0, go IDLE. Next request can be raised no earlier than the cycle after IDLE is re-entered (one idle cycle minimum between services).
- Ignored inputs: ack outside REQ; eoi outside SERVICE.
- Simultaneous eoi and new edges: edges latch normally. IDLE then evaluates them next cycle.
- Source held high: exactly one request per rising edge. Re-request needs src to drop and rise again.
- Outputs mask, pending, irq, vector, busy are all direct register outputs.

Test Plan:
1. Reset with src=16'h0001 held, release, hold 10 cycles -> irq stays 0, pending=0. Then mask=16'hFFFF, pulse src[5] -> irq=1 two cycles after edge, vector=5.
2. mask=16'hFFFF; src bits 3 and 9 rise same cycle -> vector=9. ack -> pending=16'h0008, busy=1. eoi -> after one IDLE cycle irq=1, vector=3.
3. Pre-emption: request on bit 2 in REQ, no ack; bit 12 rises -> vector changes 2->12 two cycles later. ack -> pending[12] cleared, pending[2] still 1.
4. Masking: mask=16'h0000, pulse src[7] -> pending[7]=1, irq=0. Write mask=16'h0080 -> irq=1, vector=7. While in REQ write mask=0 -> irq drops, state IDLE, pending[7] still 1.
5. Same-cycle set/clear: in REQ with vector=4, new rising edge on src[4] coincident with ack -> pending[4] remains 1, busy=1. After eoi, irq re-asserts with vector=4.
6. Reset mid-SERVICE (busy=1, pending=16'h0100) -> next cycle busy=0, irq=0, pending=0, mask=0. Stray eoi and ack afterwards have no effect.

Source files
------------

// File: rtl/irq_prio_ctrl.sv
// Interrupt priority controller: edge-latched, masked sources with an irq/ack/eoi handshake.
// Latency: src rise -> pending after 1 edge -> irq after 2 edges; eoi -> next irq after 2 edges.
// Backpressure: irq holds until ack or until every request is masked off; one interrupt in service at a time.

module prio_enc #(
  parameter int WIDTH = 4
) (
  input  logic [(1<<WIDTH)-1:0] req,
  output logic [WIDTH-1:0]      idx
);

  // Scan upward so the highest set bit is the last one written; 0 when nothing is set.
  always_comb begin
    idx = '0;
    for (int i = 0; i < (1 << WIDTH); i++) begin
      if (req[i]) idx = WIDTH'(i);
    end
  end

endmodule

module irq_prio_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(1<<WIDTH)-1:0] src,
  input  logic                  mask_we,
  input  logic [(1<<WIDTH)-1:0] mask_din,
  output logic [(1<<WIDTH)-1:0] mask,
  output logic [(1<<WIDTH)-1:0] pending,
  output logic                  irq,
  output logic [WIDTH-1:0]      vector,
  input  logic                  ack,
  input  logic                  eoi,
  output logic                  busy
);

  localparam int M = 1 << WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     src_q;
  logic [M-1:0]     pending_q, pending_d;
  logic [M-1:0]     mask_q, mask_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] vector_q, vector_d;
  logic             busy_q, busy_d;

  logic [M-1:0]     edge_vec;
  logic [M-1:0]     clr_vec;
  logic [M-1:0]     req;
  logic [WIDTH-1:0] sel;

  assign edge_vec = src & ~src_q;
  assign req      = pending_q & mask_q;

  prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
    .req (req),
    .idx (sel)
  );

  // Handshake sequencing and register next-state; a new edge wins over a same-cycle ack clear.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    vector_d = vector_q;
    busy_d   = busy_q;
    clr_vec  = '0;
    mask_d   = mask_we ? mask_din : mask_q;

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          vector_d = sel;
          irq_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (req == '0) begin
          // Everything masked off: withdraw even if ack arrives now.
          irq_d   = 1'b0;
          state_d = IDLE;
        end else if (ack) begin
          clr_vec  = M'(1) << vector_q;
          irq_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = SERVICE;
        end else begin
          vector_d = sel;
        end
      end
      SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    pending_d = (pending_q & ~clr_vec) | edge_vec;
  end

  // State registers; src history keeps tracking through reset so held-high sources make no edge.
  always_ff @(posedge clk) begin
    src_q <= src;
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
      vector_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      vector_q  <= vector_d;
      busy_q    <= busy_d;
    end
  end

  assign mask    = mask_q;
  assign pending = pending_q;
  assign irq     = irq_q;
  assign vector  = vector_q;
  assign busy    = busy_q;

endmodule
